// File: rtl/axi_prefetch_pkg.sv
// Shared constants for the AXI prefetch request path: payload field widths
// (address + id + len packed by the caller) and the default FIFO depth.
package axi_prefetch_pkg;

  localparam int ADDR_W             = 48;
  localparam int ID_W               = 8;
  localparam int LEN_W              = 8;
  localparam int REQ_W              = ADDR_W + ID_W + LEN_W;
  localparam int DEFAULT_DEPTH_LOG2 = 2;

endpackage

// File: rtl/axi_req_fifo_mem.sv
// Storage array for axi_req_fifo: one synchronous write port and one
// asynchronous read port, so it maps directly onto a vendor LUTRAM.
// Contents are never reset; the control logic tracks validity.
module axi_req_fifo_mem
  import axi_prefetch_pkg::*;
#(
  parameter int DATA_WIDTH = REQ_W,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [1 << DEPTH_LOG2];

  // Write the accepted request into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_req_fifo.sv
// Ready/valid request FIFO sitting upstream of the AXI delay gate on AR/AW.
// Absorbs requests while the gate holds ready low, keeps m_data/m_valid stable
// while the gate masks, and registers s_ready so there is no combinational
// path from m_ready back to s_ready.
// Optional build macro: AXI_REQ_FIFO_STATS_EN adds stall_cycles and max_count.
module axi_req_fifo
  import axi_prefetch_pkg::*;
#(
  parameter int DATA_WIDTH = REQ_W,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int AFULL_LVL  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  almost_full
`ifdef AXI_REQ_FIFO_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [DEPTH_LOG2:0]   max_count
`endif
);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(1 << DEPTH_LOG2);
  localparam cnt_t AFULL_C = cnt_t'(AFULL_LVL);

  logic push;
  logic pop;
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic m_valid_q, m_valid_d;
  logic s_ready_q, s_ready_d;
  logic afull_q, afull_d;

  // Next-state: pointers and occupancy, with flush overriding both handshakes;
  // flags are derived from the next count so they are registered.
  always_comb begin
    push      = s_valid & s_ready_q;
    pop       = m_valid_q & m_ready;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
    m_valid_d = (count_d != '0);
    s_ready_d = (count_d != DEPTH_C);
    afull_d   = (count_d >= AFULL_C);
  end

  // Control state register; s_ready stays low during reset and rises one
  // cycle after rst deasserts.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      afull_q   <= afull_d;
    end
  end

  axi_req_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata (s_data),
    .raddr (rd_ptr_q),
    .rdata (m_data)
  );

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign count       = count_q;
  assign almost_full = afull_q;

`ifdef AXI_REQ_FIFO_STATS_EN
  logic [31:0] stall_q, stall_d;
  cnt_t        max_q, max_d;

  // Stall counter saturates at all-ones; peak tracks the next occupancy so
  // it lines up with count. Flush does not clear either.
  always_comb begin
    stall_d = stall_q;
    if (s_valid && !s_ready_q && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    max_d = (count_d > max_q) ? count_d : max_q;
  end

  // Statistics registers, cleared by rst only.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      max_q   <= '0;
    end else begin
      stall_q <= stall_d;
      max_q   <= max_d;
    end
  end

  assign stall_cycles = stall_q;
  assign max_count    = max_q;
`endif

endmodule

// File: tb/tb_axi_req_fifo.sv
// Scoreboard bench for axi_req_fifo (DEPTH=4, AFULL_LVL=3, 64-bit payload).
// Stimulus pushes each accepted word's expected value into exp_q; the monitor
// compares m_data against the queue head every valid cycle and pops on a
// completed handshake.
module tb_axi_req_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  count;
  logic        almost_full;
`ifdef AXI_REQ_FIFO_STATS_EN
  logic [31:0] stall_cycles;
  logic [2:0]  max_count;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];

  axi_req_fifo #(
    .DATA_WIDTH (64),
    .DEPTH_LOG2 (2),
    .AFULL_LVL  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .count        (count),
    .almost_full  (almost_full)
`ifdef AXI_REQ_FIFO_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .max_count    (max_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare output against scoreboard head, pop on handshake.
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (exp_q.size() == 0) begin
        check("mon_unexpected_valid", {63'd0, m_valid}, 64'd0);
      end else begin
        check("mon_data", m_data, exp_q[0]);
        if (m_ready && !flush) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a [4];
    a[0] = 64'hA0A0_0000_0000_00A0;
    a[1] = 64'hA1A1_0000_0000_00A1;
    a[2] = 64'hA2A2_0000_0000_00A2;
    a[3] = 64'hA3A3_0000_0000_00A3;

    rst = 1'b1; flush = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;

    // 1. reset then fill
    step(); step();
    rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_afull", 64'(almost_full), 64'd0);
    step();
    check("s_ready_rise", 64'(s_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      s_data = a[i]; s_valid = 1'b1; exp_q.push_back(a[i]);
      step();
      check("fill_count", 64'(count), 64'(i + 1));
      check("fill_afull", 64'(almost_full), (i + 1 >= 3) ? 64'd1 : 64'd0);
      check("fill_s_ready", 64'(s_ready), (i + 1 == 4) ? 64'd0 : 64'd1);
    end
    s_valid = 1'b0;
    check("fill_m_valid", 64'(m_valid), 64'd1);

    // 2. drain with gated ready
    for (int i = 0; i < 8; i++) begin
      step();
      check("hold_data", m_data, a[0]);
      check("hold_valid", 64'(m_valid), 64'd1);
    end
    m_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check("drain_data", m_data, a[i]);
    end
    step();
    m_ready = 1'b0;
    check("drain_empty_valid", 64'(m_valid), 64'd0);
    check("drain_empty_count", 64'(count), 64'd0);

    // 3. streaming
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 64'hB000_0000_0000_0000 + 64'(i); s_valid = 1'b1;
      exp_q.push_back(s_data);
      step();
      check("stream_count", 64'(count), 64'd1);
      check("stream_valid", 64'(m_valid), 64'd1);
    end
    s_valid = 1'b0;
    step();
    m_ready = 1'b0;
    check("stream_end_count", 64'(count), 64'd0);

    // 4. wrap-around
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) begin
        s_data = 64'hC000_0000_0000_0000 + 64'(r * 16 + k); s_valid = 1'b1;
        exp_q.push_back(s_data);
        step();
      end
      s_valid = 1'b0;
      check("wrap_count3", 64'(count), 64'd3);
      m_ready = 1'b1;
      step(); step(); step();
      m_ready = 1'b0;
      check("wrap_count0", 64'(count), 64'd0);
    end

    // 5. flush while full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      s_data = 64'hD000_0000_0000_0000 + 64'(i); s_valid = 1'b1;
      exp_q.push_back(s_data);
      step();
    end
    check("pre_flush_count", 64'(count), 64'd4);
    s_data = 64'hDEAD_BEEF_DEAD_BEEF; flush = 1'b1; m_ready = 1'b1;
    step();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    exp_q.delete();
    check("flush_count", 64'(count), 64'd0);
    check("flush_m_valid", 64'(m_valid), 64'd0);
    check("flush_s_ready", 64'(s_ready), 64'd1);
    check("flush_afull", 64'(almost_full), 64'd0);
    s_data = 64'hE000_0000_0000_00E0; s_valid = 1'b1; exp_q.push_back(s_data);
    step();
    s_valid = 1'b0;
    check("post_flush_data", m_data, 64'hE000_0000_0000_00E0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("post_flush_empty", 64'(count), 64'd0);

    // reset mid-operation drops entries
    s_data = 64'hF0; s_valid = 1'b1; exp_q.push_back(s_data);
    step();
    s_data = 64'hF1; exp_q.push_back(s_data);
    step();
    s_valid = 1'b0;
    check("mid_count", 64'(count), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_s_ready", 64'(s_ready), 64'd0);
    step();

`ifdef AXI_REQ_FIFO_STATS_EN
    // 6. statistics
    for (int i = 0; i < 4; i++) begin
      s_data = 64'h5000 + 64'(i); s_valid = 1'b1; exp_q.push_back(s_data);
      step();
    end
    for (int i = 0; i < 5; i++) step();
    s_valid = 1'b0;
    check("stall_cycles", 64'(stall_cycles), 64'd5);
    check("max_count", 64'(max_count), 64'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    check("stall_after_flush", 64'(stall_cycles), 64'd5);
    check("max_after_flush", 64'(max_count), 64'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("stall_after_rst", 64'(stall_cycles), 64'd0);
    check("max_after_rst", 64'(max_count), 64'd0);
    step();
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
